// File: rtl/signal_router.sv
// Demultiplexes one AXI-Stream input onto output A or B through a single-entry
// holding register; route changes wait until the held sample has drained.
module signal_router #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  SYS_aclk,
  input  logic                  SYS_aresetn,
  input  logic                  switch,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_a_tdata,
  output logic                  m_axis_a_tvalid,
  input  logic                  m_axis_a_tready,
  output logic [DATA_WIDTH-1:0] m_axis_b_tdata,
  output logic                  m_axis_b_tvalid,
  input  logic                  m_axis_b_tready,
  output logic                  route,
  output logic [7:0]            switch_count
);

  typedef enum logic [1:0] {
    ROUTE_A = 2'd0,
    ROUTE_B = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_sync1, r_sync2;
  logic                  r_init;
  logic                  r_route;
  logic                  r_hold_valid, r_hold_dest;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic [7:0]            r_switch_count;

  logic w_sel_sync, w_dest_ready, w_in_acc, w_out_acc, w_drain_exit;

  assign w_sel_sync   = r_sync2;
  assign w_dest_ready = r_hold_dest ? m_axis_b_tready : m_axis_a_tready;
  assign w_out_acc    = r_hold_valid && w_dest_ready;
  assign w_in_acc     = s_axis_tvalid && s_axis_tready;

  // r_init holds off the first accept until one edge after reset release.
  always_comb begin
    s_axis_tready = 1'b0;
    w_state_nxt   = r_state;
    w_drain_exit  = 1'b0;
    case (r_state)
      ROUTE_A, ROUTE_B: begin
        s_axis_tready = r_init && (!r_hold_valid || w_dest_ready);
        if (w_sel_sync != r_route) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!r_hold_valid) begin
          w_drain_exit = 1'b1;
          w_state_nxt  = w_sel_sync ? ROUTE_B : ROUTE_A;
        end
      end
      default: w_state_nxt = ROUTE_A;
    endcase
  end

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      r_state <= ROUTE_A;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_init  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sync1 <= switch;
      r_sync2 <= r_sync1;
      r_init  <= 1'b1;
    end
  end

  // A bounce back to the old route still drains, but is not counted.
  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      r_route        <= 1'b0;
      r_switch_count <= 8'd0;
    end else if (w_drain_exit) begin
      r_route <= w_sel_sync;
      if (w_sel_sync != r_route) r_switch_count <= r_switch_count + 8'd1;
    end
  end

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      r_hold_valid <= 1'b0;
      r_hold_dest  <= 1'b0;
      r_hold_data  <= '0;
    end else if (w_in_acc) begin
      r_hold_valid <= 1'b1;
      r_hold_dest  <= r_route;
      r_hold_data  <= s_axis_tdata;
    end else if (w_out_acc) begin
      r_hold_valid <= 1'b0;
    end
  end

  assign m_axis_a_tdata  = r_hold_data;
  assign m_axis_b_tdata  = r_hold_data;
  assign m_axis_a_tvalid = r_hold_valid && !r_hold_dest;
  assign m_axis_b_tvalid = r_hold_valid && r_hold_dest;
  assign route           = r_route;
  assign switch_count    = r_switch_count;

endmodule

// File: tb/tb_signal_router.sv
// Bench for signal_router: constant vector table, directed corner sequences and
// a random run, all cross-checked against a queue-based transaction model.
module tb_signal_router;

  logic        clk;
  logic        rst_n;
  logic        sw;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] a_tdata, b_tdata;
  logic        a_tvalid, b_tvalid;
  logic        a_tready, b_tready;
  logic        route;
  logic [7:0]  cnt;

  signal_router #(.DATA_WIDTH(16)) dut (
    .SYS_aclk        (clk),
    .SYS_aresetn     (rst_n),
    .switch          (sw),
    .s_axis_tdata    (s_tdata),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tready   (s_tready),
    .m_axis_a_tdata  (a_tdata),
    .m_axis_a_tvalid (a_tvalid),
    .m_axis_a_tready (a_tready),
    .m_axis_b_tdata  (b_tdata),
    .m_axis_b_tvalid (b_tvalid),
    .m_axis_b_tready (b_tready),
    .route           (route),
    .switch_count    (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction model: samples in flight with the destination fixed at accept.
  typedef struct {
    logic [15:0] d;
    logic        dest;
  } item_t;
  item_t       m_q[$];
  logic [15:0] m_last;
  logic        m_init, m_h1, m_h2, m_drain, m_route;
  int          m_count, m_acc, m_emit;

  int          dut_acc, dut_emit, route_changes;
  logic        prev_route;
  logic [15:0] watch;
  int          watch_a, watch_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic model_tready();
    if (!m_init || m_drain) return 1'b0;
    if (m_q.size() == 0) return 1'b1;
    return m_q[0].dest ? b_tready : a_tready;
  endfunction

  function automatic logic model_valid(input logic dest);
    if (m_q.size() == 0) return 1'b0;
    return m_q[0].dest == dest;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_last = '0; m_init = 0; m_h1 = 0; m_h2 = 0; m_drain = 0; m_route = 0;
    m_count = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tready"}, 32'(s_tready), 0);
    chk({tag, "_a_valid"}, 32'(a_tvalid), 0);
    chk({tag, "_b_valid"}, 32'(b_tvalid), 0);
    chk({tag, "_data"}, 32'(a_tdata), 0);
    chk({tag, "_route"}, 32'(route), 0);
    chk({tag, "_count"}, 32'(cnt), 0);
  endtask

  task automatic drive(input logic sv, input logic tv, input logic [15:0] td,
                       input logic ar, input logic br);
    sw = sv; s_tvalid = tv; s_tdata = td; a_tready = ar; b_tready = br;
    #1;
  endtask

  task automatic check_model();
    chk("tready", 32'(s_tready), 32'(model_tready()));
    chk("a_valid", 32'(a_tvalid), 32'(model_valid(1'b0)));
    chk("b_valid", 32'(b_tvalid), 32'(model_valid(1'b1)));
    chk("a_data", 32'(a_tdata), 32'(m_last));
    chk("b_data", 32'(b_tdata), 32'(m_last));
    chk("route", 32'(route), 32'(m_route));
    chk("count", 32'(cnt), 32'(m_count[7:0]));
    if (s_tvalid && s_tready) dut_acc++;
    if (a_tvalid && a_tready) begin dut_emit++; if (a_tdata == watch) watch_a++; end
    if (b_tvalid && b_tready) begin dut_emit++; if (b_tdata == watch) watch_b++; end
    if (route != prev_route) route_changes++;
    prev_route = route;
  endtask

  task automatic advance();
    logic sel, was_empty, in_acc, out_acc;
    sel       = m_h2;
    was_empty = (m_q.size() == 0);
    in_acc    = s_tvalid && model_tready();
    out_acc   = 1'b0;
    if (!was_empty) out_acc = m_q[0].dest ? b_tready : a_tready;
    @(posedge clk);
    if (out_acc) begin m_q.delete(0); m_emit++; end
    if (in_acc) begin
      m_q.push_back(item_t'{d: s_tdata, dest: m_route});
      m_last = s_tdata;
      m_acc++;
    end
    if (!m_drain) begin
      if (sel != m_route) m_drain = 1;
    end else if (was_empty) begin
      if (sel != m_route) m_count++;
      m_route = sel;
      m_drain = 0;
    end
    m_h2 = m_h1; m_h1 = sw; m_init = 1;
    #1;
  endtask

  task automatic step(input logic sv, input logic tv, input logic [15:0] td,
                      input logic ar, input logic br);
    drive(sv, tv, td, ar, br);
    check_model();
    advance();
  endtask

  // Leaves the bench at posedge+1 with reset just released.
  task automatic do_reset();
    rst_n = 0;
    sw = 0; s_tvalid = 0; s_tdata = '0; a_tready = 1; b_tready = 1;
    #1;
    chk_reset_vals("rst");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    rst_n = 1;
    model_reset();
    prev_route = 0;
  endtask

  typedef struct {
    logic        sw, tv;
    logic [15:0] td;
    logic        ar, br;
    logic        e_rdy, e_av, e_bv;
    logic [15:0] e_data;
    logic        e_route;
    logic [7:0]  e_cnt;
  } vec_t;
  vec_t vecs [0:11];

  logic sw_r;
  int   sw_left;

  initial begin
    rst_n = 0;
    watch = 16'hDEAD; watch_a = 0; watch_b = 0;
    dut_acc = 0; dut_emit = 0; m_acc = 0; m_emit = 0; route_changes = 0;

    // Basic A traffic, then a route change to B after sample 7.
    vecs[0]  = '{1'b0, 1'b1, 16'd14,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0,     1'b0, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 16'd14,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0,     1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b1, 16'hFFE3,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd14,    1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 16'd0,     1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hFFE3,  1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 16'd7,     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFE3,  1'b0, 8'd0};
    vecs[5]  = '{1'b1, 1'b0, 16'd0,     1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd7,     1'b0, 8'd0};
    vecs[6]  = '{1'b1, 1'b0, 16'd0,     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd7,     1'b0, 8'd0};
    vecs[7]  = '{1'b1, 1'b0, 16'd0,     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd7,     1'b0, 8'd0};
    vecs[8]  = '{1'b1, 1'b1, 16'd16,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd7,     1'b0, 8'd0};
    vecs[9]  = '{1'b1, 1'b1, 16'd16,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd7,     1'b1, 8'd1};
    vecs[10] = '{1'b1, 1'b0, 16'd0,     1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd16,    1'b1, 8'd1};
    vecs[11] = '{1'b1, 1'b0, 16'd0,     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd16,    1'b1, 8'd1};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].sw, vecs[i].tv, vecs[i].td, vecs[i].ar, vecs[i].br);
      chk($sformatf("v%0d_tready", i), 32'(s_tready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_a_valid", i), 32'(a_tvalid), 32'(vecs[i].e_av));
      chk($sformatf("v%0d_b_valid", i), 32'(b_tvalid), 32'(vecs[i].e_bv));
      chk($sformatf("v%0d_data", i), 32'(a_tdata), 32'(vecs[i].e_data));
      chk($sformatf("v%0d_route", i), 32'(route), 32'(vecs[i].e_route));
      chk($sformatf("v%0d_count", i), 32'(cnt), 32'(vecs[i].e_cnt));
      check_model();
      advance();
    end

    // Backpressure drain: 5 stalled on A while switch goes high.
    do_reset();
    watch = 16'd5; watch_a = 0; watch_b = 0;
    step(0, 0, 0, 0, 1);
    step(0, 1, 16'd5, 0, 1);
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 16'd99, 0, 1);
      chk("bp_stall_tready", 32'(s_tready), 0);
      chk("bp_stall_route", 32'(route), 0);
      check_model();
      advance();
    end
    step(1, 1, 16'd99, 1, 1);
    drive(1, 1, 16'd99, 0, 1);
    chk("bp_route_before_exit", 32'(route), 0);
    check_model();
    advance();
    drive(1, 0, 16'd0, 0, 1);
    chk("bp_route_after_exit", 32'(route), 1);
    check_model();
    advance();
    repeat (3) step(1, 0, 0, 1, 1);
    chk("bp_5_once_on_a", 32'(watch_a), 1);
    chk("bp_5_never_on_b", 32'(watch_b), 0);

    // Aborted switch: 3-cycle pulse while A is stalled.
    do_reset();
    watch = 16'h0021; watch_a = 0; watch_b = 0;
    step(0, 0, 0, 0, 1);
    step(0, 1, 16'h0021, 0, 1);
    repeat (3) step(1, 0, 0, 0, 1);
    repeat (6) step(0, 0, 0, 0, 1);
    repeat (6) step(0, 0, 0, 1, 1);
    chk("abort_route", 32'(route), 0);
    chk("abort_count", 32'(cnt), 0);
    chk("abort_21_once_on_a", 32'(watch_a), 1);
    chk("abort_21_never_on_b", 32'(watch_b), 0);

    // Asynchronous reset while a sample is held in DRAIN.
    do_reset();
    watch = 16'h0055; watch_a = 0; watch_b = 0;
    step(0, 0, 0, 0, 1);
    step(0, 1, 16'h0055, 0, 1);
    repeat (5) step(1, 0, 0, 0, 1);
    chk("mid_drain_a_valid", 32'(a_tvalid), 1);
    #2 rst_n = 0;
    #1;
    chk_reset_vals("async_rst");
    do_reset();
    repeat (6) step(0, 0, 0, 1, 1);
    chk("rst_55_never_emitted", 32'(watch_a + watch_b), 0);

    // 256 alternating route changes under continuous input.
    do_reset();
    route_changes = 0; dut_acc = 0; dut_emit = 0;
    for (int k = 0; k < 256; k++)
      for (int j = 0; j < 8; j++)
        step(k[0] == 1'b0, 1, 16'(k * 8 + j), 1, 1);
    repeat (4) step(0, 0, 0, 1, 1);
    chk("wrap_count", 32'(cnt), 0);
    chk("wrap_route_changes", 32'(route_changes), 256);
    chk("wrap_acc_eq_emit", 32'(dut_emit), 32'(dut_acc));

    // Random traffic, stalls and switch pulses of any length.
    do_reset();
    dut_acc = 0; dut_emit = 0; m_acc = 0; m_emit = 0;
    sw_r = 0; sw_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (sw_left == 0) begin
        sw_r    = 1'($urandom_range(0, 1));
        sw_left = $urandom_range(1, 10);
      end
      sw_left--;
      step(sw_r, $urandom_range(0, 3) != 0, 16'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    repeat (10) step(sw_r, 0, 0, 1, 1);
    chk("rand_acc", 32'(dut_acc), 32'(m_acc));
    chk("rand_emit", 32'(dut_emit), 32'(m_emit));
    chk("rand_acc_eq_emit", 32'(dut_emit), 32'(dut_acc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/signal_router.md
SIGNAL_ROUTER -- requirements
Module: signal_router

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16, giving the sample width in bits.
REQ-002 The port list SHALL be as follows (clock and reset first):
- SYS_aclk, input, 1 bit: single system clock; all logic is rising-edge.
- SYS_aresetn, input, 1 bit: reset, asynchronous, active-low.
- switch, input, 1 bit: route select, asynchronous to SYS_aclk (0 = output A, 1 = output B).
- s_axis_tdata, input, DATA_WIDTH bits: input sample, two's complement.
- s_axis_tvalid, input, 1 bit: input sample valid.
- s_axis_tready, output, 1 bit: input sample accepted when high.
- m_axis_a_tdata, output, DATA_WIDTH bits: output A sample.
- m_axis_a_tvalid, output, 1 bit: output A valid.
- m_axis_a_tready, input, 1 bit: output A ready.
- m_axis_b_tdata, output, DATA_WIDTH bits: output B sample.
- m_axis_b_tvalid, output, 1 bit: output B valid.
- m_axis_b_tready, input, 1 bit: output B ready.
- route, output, 1 bit: currently active destination (0 = A, 1 = B).
- switch_count, output, 8 bits: number of completed route changes, wrapping.

Function
REQ-003 The block SHALL route one input sample stream to exactly one of two outputs; it is the demultiplexing counterpart of signal_switch.
REQ-004 switch SHALL pass through a two-flop synchronizer; the synchronized value is sel_sync.
REQ-005 The block SHALL hold a single-entry holding register: hold_data (DATA_WIDTH bits), hold_valid, and hold_dest.
REQ-006 The state machine SHALL have three states:
- ROUTE_A: active destination is A.
- ROUTE_B: active destination is B.
- DRAIN: a route change is in progress.
REQ-007 A transfer on any port SHALL occur when tvalid and tready are both high on a rising edge.
REQ-008 In ROUTE_A and ROUTE_B, s_axis_tready SHALL equal (!hold_valid || ready of hold_dest).
REQ-009 In DRAIN, s_axis_tready SHALL be 0.
REQ-010 An accepted input sample SHALL be loaded into hold_data on the same edge, with hold_dest set to the current route.
REQ-011 Latency SHALL be one cycle: a sample accepted at edge n is presented on the destination output after edge n.
REQ-012 m_axis_a_tvalid SHALL equal (hold_valid && hold_dest==0), and m_axis_b_tvalid SHALL equal (hold_valid && hold_dest==1).
REQ-013 Both m_axis_*_tdata SHALL mirror hold_data; only tvalid identifies the destination.
REQ-014 hold_valid SHALL clear when the destination accepts the sample and no new input is accepted on the same edge.
REQ-015 On a simultaneous input accept and output accept, hold_valid SHALL remain 1 and hold_data SHALL take the new sample, giving full throughput of one sample per cycle.
REQ-016 A held sample SHALL remain stable (data and valid) until it is accepted; it SHALL never be dropped or duplicated.
REQ-017 In ROUTE_x, when sel_sync differs from route, the next state SHALL be DRAIN; an input accepted on that same edge still goes to the old route.
REQ-018 DRAIN SHALL be left when hold_valid is 0. On that edge, route SHALL take sel_sync, the state SHALL become ROUTE_A or ROUTE_B accordingly, and switch_count SHALL increment by 1 (255 wraps to 0).
REQ-019 If sel_sync returns to the old route during DRAIN, the block SHALL still complete DRAIN, return to the old route, and NOT increment switch_count.
REQ-020 The route output SHALL change only on the DRAIN exit edge.
REQ-021 Stalls on the inactive output's tready SHALL have no effect.
REQ-022 A switch pulse shorter than 2 SYS_aclk cycles MAY be missed; a level held for 3 or more cycles SHALL always be acted on.

Reset
REQ-023 While SYS_aresetn is 0, the following SHALL hold immediately, independent of the clock:
- state is ROUTE_A, route is 0;
- hold_valid is 0, hold_data is 0;
- all tvalid outputs are 0, s_axis_tready is 0;
- switch_count is 0;
- synchronizer flops are 0.
REQ-024 The first input accept SHALL be possible on the second rising edge after SYS_aresetn deasserts.
REQ-025 A reset asserted mid-DRAIN or with hold_valid=1 SHALL discard the held sample and return to the REQ-023 values.

Verification
REQ-026 Basic A route: switch=0, both treadys=1, input 14 then -29 (16'hFFE3) in consecutive cycles. Required: m_axis_a shows 14 then 16'hFFE3 one cycle later each, m_axis_b_tvalid stays 0, switch_count=0.
REQ-027 Route change: switch=1 held after sample 7 is accepted. Required:
- route becomes 1 within 4 cycles;
- sample 16 is delivered only on B;
- 7 appears only on A;
- switch_count=1.
REQ-028 Backpressure drain: m_axis_a_tready=0 with 5 held on A, then switch=1. Required:
- s_axis_tready stays 0 and route stays 0 while A stalls;
- after A tready=1 for one cycle, 5 transfers once on A;
- route becomes 1 on the next edge.
REQ-029 Aborted switch: switch pulses high for 3 cycles while A is stalled. Required: the block returns to route 0, switch_count is unchanged, no sample is lost or duplicated.
REQ-030 Reset mid-operation: assert SYS_aresetn=0 asynchronously while hold_valid=1 in DRAIN. Required: all outputs at REQ-023 values before the next edge, and the held sample is never emitted.
REQ-031 Wrap and throughput: perform 256 alternating route changes with continuous valid input. Required:
- switch_count wraps to 0;
- every sample accepted equals exactly one sample emitted, in order;
- one sample per cycle outside DRAIN.
